// File: rtl/ram_march_bist.sv
// March BIST engine (W, R/W~, descending R/W, R) driving a single-port RAM with 1-cycle registered read.
// Optional STOP_ON_FAIL_EN: halt at the first mismatch instead of completing the march.
module ram_march_bist #(
  parameter int unsigned    AW      = 8,
  parameter int unsigned    DW      = 8,
  parameter logic [DW-1:0]  PATTERN = DW'(8'h55)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [7:0]    err_count,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d_in,
  input  logic [DW-1:0] ram_d_out
);

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_MIN = '0;

  typedef enum logic [3:0] {
    S_IDLE, S_M0_W,
    S_M1_R, S_M1_C, S_M1_W,
    S_M2_R, S_M2_C, S_M2_W,
    S_M3_R, S_M3_C,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   w_addr_nxt;
  logic [AW-1:0]   r_fail_addr;
  logic [DW-1:0]   r_fail_data;
  logic [7:0]      r_err_count;
  logic            w_wr;
  logic            w_rd;
  logic [DW-1:0]   w_d_in;
  logic            w_chk;
  logic [DW-1:0]   w_exp;
  logic            w_mis;
  logic            w_accept;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mis    = w_chk && (ram_d_out != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_d_in      = '0;
    w_chk       = 1'b0;
    w_exp       = PATTERN;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_M0_W;
          w_addr_nxt  = ADDR_MIN;
        end
      end
      S_M0_W: begin
        w_wr        = 1'b1;
        w_d_in      = PATTERN;
        w_addr_nxt  = r_addr + 1'b1;
        w_state_nxt = (r_addr == ADDR_MAX) ? S_M1_R : S_M0_W;
      end
      S_M1_R: begin
        w_rd        = 1'b1;
        w_state_nxt = S_M1_C;
      end
      S_M1_C: begin
        w_chk       = 1'b1;
        w_exp       = PATTERN;
        w_state_nxt = (STOP_ON_FAIL && w_mis) ? S_DONE : S_M1_W;
      end
      S_M1_W: begin
        w_wr   = 1'b1;
        w_d_in = ~PATTERN;
        // M2 descends, so the last M1 address is also the first M2 address
        if (r_addr == ADDR_MAX) begin
          w_state_nxt = S_M2_R;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = S_M1_R;
        end
      end
      S_M2_R: begin
        w_rd        = 1'b1;
        w_state_nxt = S_M2_C;
      end
      S_M2_C: begin
        w_chk       = 1'b1;
        w_exp       = ~PATTERN;
        w_state_nxt = (STOP_ON_FAIL && w_mis) ? S_DONE : S_M2_W;
      end
      S_M2_W: begin
        w_wr   = 1'b1;
        w_d_in = PATTERN;
        if (r_addr == ADDR_MIN) begin
          w_state_nxt = S_M3_R;
        end else begin
          w_addr_nxt  = r_addr - 1'b1;
          w_state_nxt = S_M2_R;
        end
      end
      S_M3_R: begin
        w_rd        = 1'b1;
        w_state_nxt = S_M3_C;
      end
      S_M3_C: begin
        w_chk      = 1'b1;
        w_exp      = PATTERN;
        if (STOP_ON_FAIL && w_mis) begin
          w_state_nxt = S_DONE;
        end else if (r_addr == ADDR_MAX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt  = r_addr + 1'b1;
          w_state_nxt = S_M3_R;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
      end
    endcase
  end

  // first-failure capture only while the counter is still zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_accept) begin
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_mis) begin
      if (r_err_count == 8'd0) begin
        r_fail_addr <= r_addr;
        r_fail_data <= ram_d_out;
      end
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err_count == 8'd0);
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign err_count = r_err_count;
  assign ram_wr    = w_wr;
  assign ram_rd    = w_rd;
  assign ram_addr  = r_addr;
  assign ram_d_in  = w_d_in;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a behavioural 1-cycle-read RAM and injectable faults.
module tb_ram_march_bist;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass, ram_wr, ram_rd;
  logic [7:0] fail_addr, fail_data, err_count, ram_addr, ram_d_in;
  logic [7:0] ram_d_out = 8'h00;

  ram_march_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_d_in(ram_d_in),
    .ram_d_out(ram_d_out)
  );

  always #5 clk = ~clk;

  // fault_mode: 0 none, 1 bit0 of 0x3A stuck at 1, 2 d_out stuck at 0
  int         fault_mode = 0;
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_wr)
      mem[ram_addr] <= (fault_mode == 1 && ram_addr == 8'h3A) ? (ram_d_in | 8'h01) : ram_d_in;
    if (ram_rd)
      ram_d_out <= (fault_mode == 2) ? 8'h00 : mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc, nwr, nrd;
  bit bad;
  logic first_done;
  logic [7:0] first_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then count busy cycles; optional extra start or reset at a given busy cycle.
  task automatic run(input int start_at, input int rst_at);
    cyc = 0; nwr = 0; nrd = 0; bad = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    first_done = done;
    first_err  = err_count;
    while (busy && cyc < 5000) begin
      cyc++;
      if (ram_wr) nwr++;
      if (ram_rd) nrd++;
      if (ram_wr && ram_rd) bad = 1'b1;
      if (!ram_wr && ram_d_in !== 8'h00) bad = 1'b1;
      if (ram_wr && ram_d_in !== 8'h55 && ram_d_in !== 8'hAA) bad = 1'b1;
      start = (cyc == start_at);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_fdata", fail_data, 0);
    chk("rst_wr_rd", {ram_wr, ram_rd}, 0);
    chk("rst_addr_din", {ram_addr, ram_d_in}, 0);
    @(negedge clk) rst_n = 1'b1;

    // fault-free march
    run(-1, -1);
    chk("t1_cycles", cyc, 2304);
    chk("t1_nwr", nwr, 768);
    chk("t1_nrd", nrd, 768);
    chk("t1_strobes", bad, 0);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);
    chk("t1_faddr", fail_addr, 0);

    fault_mode = 1;
    run(-1, -1);
`ifdef STOP_ON_FAIL_EN
    chk("t3_cycles", cyc, 1617);
    chk("t3_nwr", nwr, 709);
    chk("t3_done", done, 1);
    chk("t3_err", err_count, 1);
    chk("t3_pass", pass, 0);
    chk("t3_faddr", fail_addr, 8'h3A);
    repeat (3) @(negedge clk);
    chk("t3_no_wr", {ram_wr, ram_rd, done}, 3'b001);
`else
    chk("t2_cycles", cyc, 2304);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_faddr", fail_addr, 8'h3A);
    chk("t2_fdata", fail_data, 8'hAB);
    chk("t2_err", err_count, 1);
`endif

    // restart from DONE clears status; reset mid-run kills strobes at once
    fault_mode = 0;
    run(-1, 1000);
    chk("t4_restart_done", first_done, 0);
    chk("t4_restart_err", first_err, 0);
    chk("t4_rst_cycle", cyc, 1000);
    chk("t4_rst_strobes", {ram_wr, ram_rd, busy}, 0);
    chk("t4_rst_status", {done, err_count, fail_addr}, 0);
    @(negedge clk) rst_n = 1'b1;
    run(-1, -1);
    chk("t4_cycles", cyc, 2304);
    chk("t4_pass", pass, 1);

    // extra start while busy is ignored
    run(500, -1);
    chk("t5_cycles", cyc, 2304);
    chk("t5_pass", {done, pass}, 2'b11);

    fault_mode = 2;
    run(-1, -1);
`ifdef STOP_ON_FAIL_EN
    chk("t6_err", err_count, 1);
    chk("t6_cycles", cyc, 258);
`else
    chk("t6_err", err_count, 255);
    chk("t6_cycles", cyc, 2304);
`endif
    chk("t6_faddr", fail_addr, 8'h00);
    chk("t6_fdata", fail_data, 8'h00);
    chk("t6_pass", {done, pass}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
